dds_chirp_mc: RTL and testbench

Multi-channel direct digital synthesiser with a built-in linear frequency-sweep (chirp) engine. It is the parametrised successor of the single-channel DDS. NCH phase-coherent channels share one sweep state machine. Each channel has its own start frequency, sweep step and phase offset, and reads a quarter-wave sine table. It sits between the control/register layer and the DSP datapath, as the stimulus and local-oscillator source for mixers and filter benches.

---
 rtl/dds_pkg.sv | 38 +++
 rtl/dds_chirp_mc_if.sv | 41 ++++
 rtl/dds_qlut.sv | 70 +++++++
 rtl/dds_chirp_mc.sv | 158 +++++++++++++++
 tb/tb_dds_chirp_mc.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared types and quarter-wave table helpers for the multi-channel chirp DDS.
// The DDS_COS_EN build option (adds a cosine output) is handled in dds_qlut and dds_chirp_mc.
package dds_pkg;

    localparam int NCH_DEF = 2;
    localparam int PW_DEF  = 32;
    localparam int DW_DEF  = 10;
    localparam int AW_DEF  = 13;

    typedef enum logic [1:0] {
        TONE    = 2'd0,
        ONESHOT = 2'd1,
        REPEAT  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int qdepth(input int aw);
        return 2 ** (aw - 2);
    endfunction

    localparam int QDEPTH = qdepth(AW_DEF);

    // Half-sample offset keeps the mirrored quadrants exact, so entry k of quadrant 1
    // equals entry QDEPTH-1-k of quadrant 0.
    function automatic int qlut_entry(input int k, input int aw, input int dw);
        real amp;
        real ang;
        amp = real'((1 << (dw - 1)) - 1);
        ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(1 << aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/dds_chirp_mc_if.sv
// Control and sample bus of the chirp DDS; cos_out is present only when DDS_COS_EN is defined.
interface dds_chirp_mc_if #(
    parameter int NCH = dds_pkg::NCH_DEF,
    parameter int PW  = dds_pkg::PW_DEF,
    parameter int DW  = dds_pkg::DW_DEF
) ();

    logic                   en;
    dds_pkg::mode_t         mode;
    logic                   start;
    logic                   abort;
    logic [31:0]            sweep_len;
    logic [NCH-1:0][PW-1:0] f_start;
    logic [NCH-1:0][PW-1:0] f_step;
    logic [NCH-1:0][PW-1:0] phase;
    logic [NCH-1:0][DW-1:0] out;
    logic                   out_valid;
    logic [NCH-1:0][PW-1:0] freq_o;
    logic                   busy;
    logic                   done;
`ifdef DDS_COS_EN
    logic [NCH-1:0][DW-1:0] cos_out;
`endif

    modport master (
        output en, mode, start, abort, sweep_len, f_start, f_step, phase,
        input  out, out_valid, freq_o, busy, done
`ifdef DDS_COS_EN
        , input cos_out
`endif
    );

    modport slave (
        input  en, mode, start, abort, sweep_len, f_start, f_step, phase,
        output out, out_valid, freq_o, busy, done
`ifdef DDS_COS_EN
        , output cos_out
`endif
    );

endinterface

// File: rtl/dds_qlut.sv
// Quarter-wave sine ROM with address fold and sign restore: table read stage, then sign stage.
// With DDS_COS_EN a second read port serves the cosine at address + QD.
module dds_qlut
    import dds_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int QD = QDEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] sin_out
`ifdef DDS_COS_EN
    ,
    output logic [DW-1:0] cos_out
`endif
);

    logic [DW-2:0] rom [QD];
    logic [AW-3:0] idx;
    logic [AW-3:0] s_idx;
    logic [DW-2:0] s_mag;
    logic          s_neg;

    for (genvar k = 0; k < QD; k++) begin : g_rom
        assign rom[k] = (DW-1)'(qlut_entry(k, AW, DW));
    end

    assign idx   = addr[AW-3:0];
    assign s_idx = addr[AW-2] ? ~idx : idx;

    // NOTE: the table is constant and never reset; only the pipeline registers
    // around it are, so reset costs nothing in the ROM itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_mag   <= '0;
            s_neg   <= 1'b0;
            sin_out <= '0;
        end else if (en) begin
            s_mag   <= rom[s_idx];
            s_neg   <= addr[AW-1];
            sin_out <= s_neg ? -{1'b0, s_mag} : {1'b0, s_mag};
        end
    end

`ifdef DDS_COS_EN
    logic [1:0]    quad_c;
    logic [AW-3:0] c_idx;
    logic [DW-2:0] c_mag;
    logic          c_neg;

    assign quad_c = addr[AW-1:AW-2] + 2'd1;
    assign c_idx  = quad_c[0] ? ~idx : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_mag   <= '0;
            c_neg   <= 1'b0;
            cos_out <= '0;
        end else if (en) begin
            c_mag   <= rom[c_idx];
            c_neg   <= quad_c[1];
            cos_out <= c_neg ? -{1'b0, c_mag} : {1'b0, c_mag};
        end
    end
`endif

endmodule

// File: rtl/dds_chirp_mc.sv
// Multi-channel DDS with a shared linear-chirp sweep FSM; per-channel accumulator and phase add.
// Defining DDS_COS_EN adds a quadrature cos_out with the same latency and out_valid.
module dds_chirp_mc
    import dds_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = PW_DEF,
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF
) (
    input logic           clk,
    input logic           rst,
    dds_chirp_mc_if.slave bus
);

    state_t                 state;
    state_t                 state_n;
    logic [NCH-1:0][PW-1:0] freq;
    logic [NCH-1:0][PW-1:0] freq_n;
    logic [NCH-1:0][PW-1:0] stepped;
    logic [NCH-1:0][PW-1:0] acc;
    logic [NCH-1:0][AW-1:0] addr;
    logic [NCH-1:0][DW-1:0] sin_q;
    logic [31:0]            cnt;
    logic [31:0]            cnt_n;
    logic                   done;
    logic                   done_n;
    logic                   go;
    logic                   v1;
    logic                   v2;
    logic                   out_valid;

    assign go = bus.en && bus.start && (bus.sweep_len != '0)
             && (bus.mode == ONESHOT || bus.mode == REPEAT);

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            stepped[c] = freq[c] + bus.f_step[c];
        end
    end

    // NOTE: every output of this block gets a default first so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        freq_n  = freq;
        cnt_n   = cnt;
        done_n  = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
            freq_n  = bus.f_start;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    freq_n = bus.f_start;
                    if (go) begin
                        state_n = SWEEP;
                        cnt_n   = bus.sweep_len - 32'd1;
                    end
                end
                HOLD: begin
                    if (go) begin
                        state_n = SWEEP;
                        freq_n  = bus.f_start;
                        cnt_n   = bus.sweep_len - 32'd1;
                    end
                end
                SWEEP: begin
                    if (bus.en) begin
                        if (cnt != '0) begin
                            freq_n = stepped;
                            cnt_n  = cnt - 32'd1;
                        end else begin
                            done_n = 1'b1;
                            // A mode change mid-sweep to anything but REPEAT ends like ONESHOT.
                            if (bus.mode == REPEAT) begin
                                freq_n = bus.f_start;
                                cnt_n  = bus.sweep_len - 32'd1;
                            end else begin
                                freq_n  = stepped;
                                state_n = HOLD;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            freq  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            freq  <= freq_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    // Stage 1: phase accumulate and offset add; out_valid trails en through all three stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            addr      <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= bus.en & v2;
            if (bus.en) begin
                v1 <= 1'b1;
                v2 <= v1;
                for (int c = 0; c < NCH; c++) begin
                    acc[c]  <= acc[c] + freq[c];
                    addr[c] <= AW'((acc[c] + bus.phase[c]) >> (PW - AW));
                end
            end
        end
    end

`ifdef DDS_COS_EN
    logic [NCH-1:0][DW-1:0] cos_q;
    assign bus.cos_out = cos_q;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        dds_qlut #(
            .AW(AW),
            .DW(DW),
            .QD(qdepth(AW))
        ) u_qlut (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .addr    (addr[c]),
            .sin_out (sin_q[c])
`ifdef DDS_COS_EN
            ,
            .cos_out (cos_q[c])
`endif
        );
    end

    assign bus.out       = sin_q;
    assign bus.out_valid = out_valid;
    assign bus.freq_o    = freq;
    assign bus.busy      = (state == SWEEP);
    assign bus.done      = done;

endmodule

// File: tb/tb_dds_chirp_mc.sv
// Scoreboard bench for dds_chirp_mc: quadrature tone, en freeze, ONESHOT/REPEAT sweeps, abort, reset.
module tb_dds_chirp_mc;
    import dds_pkg::*;

    localparam logic [31:0] Q = 32'h4000_0000;

    typedef struct {
        logic [31:0] f0;
        logic [31:0] f1;
        bit          busy;
        bit          done;
        bit          chk_ov;
        bit          ov;
        bit          chk_o;
        int          o0;
    } stat_t;

    typedef struct {
        int s0;
        int s1;
        int c0;
        int c1;
    } samp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    stat_t stat_q[$];
    samp_t samp_q[$];

    dds_chirp_mc_if #(.NCH(2), .PW(32), .DW(10)) bus ();

    dds_chirp_mc #(.NCH(2), .PW(32), .DW(10), .AW(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_stat(input logic [31:0] f0, input logic [31:0] f1, input bit busy,
                            input bit done, input bit chk_ov = 1'b0, input bit ov = 1'b0,
                            input bit chk_o = 1'b0, input int o0 = 0);
        stat_t s;
        s.f0 = f0; s.f1 = f1; s.busy = busy; s.done = done;
        s.chk_ov = chk_ov; s.ov = ov; s.chk_o = chk_o; s.o0 = o0;
        stat_q.push_back(s);
    endtask

    // Monitor: status expectations are consumed one per cycle, samples on each out_valid.
    initial begin
        stat_t s;
        samp_t p;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("freq_o0", longint'(bus.freq_o[0]), longint'(s.f0));
                check("freq_o1", longint'(bus.freq_o[1]), longint'(s.f1));
                check("busy", longint'(bus.busy), longint'(s.busy));
                check("done", longint'(bus.done), longint'(s.done));
                if (s.chk_ov) check("out_valid", longint'(bus.out_valid), longint'(s.ov));
                if (s.chk_o) check("out0_held", longint'($signed(bus.out[0])), longint'(s.o0));
            end
            if (bus.out_valid && samp_q.size() > 0) begin
                p = samp_q.pop_front();
                check("out0", longint'($signed(bus.out[0])), longint'(p.s0));
                check("out1", longint'($signed(bus.out[1])), longint'(p.s1));
`ifdef DDS_COS_EN
                check("cos_out0", longint'($signed(bus.cos_out[0])), longint'(p.c0));
                check("cos_out1", longint'($signed(bus.cos_out[1])), longint'(p.c1));
`endif
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int p_s0[4] = '{0, 511, 0, -511};
        int p_s1[4] = '{511, 0, -511, 0};
        int p_c0[4] = '{511, 0, -511, 0};
        int p_c1[4] = '{0, -511, 0, 511};
        samp_t p;
        int k;
        int waited;

        // ---- Quadrature tone, then a zero-step REPEAT sweep with an en freeze ----
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = TONE; bus.start = 1'b0; bus.abort = 1'b0;
        bus.sweep_len = 32'd4;
        bus.f_start[0] = Q; bus.f_start[1] = Q;
        bus.f_step[0] = '0; bus.f_step[1] = '0;
        bus.phase[0] = '0;  bus.phase[1] = Q;
        for (int n = 0; n < 10; n++) begin
            p.s0 = p_s0[n % 4]; p.s1 = p_s1[n % 4]; p.c0 = p_c0[n % 4]; p.c1 = p_c1[n % 4];
            samp_q.push_back(p);
        end
        tick(); tick();
        exp_stat(0, 0, 0, 0, 1, 0, 1, 0);
        rst = 1'b0;
        tick();
        exp_stat(Q, Q, 0, 0, 1, 0);
        bus.en = 1'b1;
        tick();
        exp_stat(Q, Q, 0, 0, 1, 0);
        tick();
        exp_stat(Q, Q, 0, 0, 1, 0);
        tick();
        exp_stat(Q, Q, 0, 0, 1, 1, 1, 0);
        bus.mode = REPEAT; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            exp_stat(Q, Q, 1, 0, 1, 1);
            if (j == 2) bus.en = 1'b0;
            tick();
        end
        for (int f = 0; f < 5; f++) begin
            exp_stat(Q, Q, 1, 0, 1, 0, 1, -511);
            if (f == 4) bus.en = 1'b1;
            tick();
        end
        for (int j = 3; j < 9; j++) begin
            exp_stat(Q, Q, 1, (j % 4) == 0, 1, 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_stat(0, 0, 0, 0, 1, 0, 1, 0);
        tick();

        // ---- Sweeps: ignored starts, ONESHOT, REPEAT, abort+start, reset mid-sweep ----
        rst = 1'b1;
        bus.f_start[0] = 32'd0;    bus.f_start[1] = 32'd100;
        bus.f_step[0]  = 32'd1000; bus.f_step[1]  = 32'hFFFF_FFFF;
        bus.phase[0] = '0; bus.phase[1] = '0;
        bus.sweep_len = 32'd10; bus.mode = TONE; bus.en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        exp_stat(0, 100, 0, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_stat(0, 100, 0, 0);
        bus.mode = mode_t'(2'd3); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_stat(0, 100, 0, 0);
        bus.mode = ONESHOT; bus.sweep_len = 32'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_stat(0, 100, 0, 0);
        bus.sweep_len = 32'd10; bus.start = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            k = (i < 10) ? i : 10;
            exp_stat(32'(1000 * k), 32'(100 - k), i < 10, i == 10);
            bus.start = (i == 5);
            tick();
        end
        bus.start = 1'b0;
        bus.mode = REPEAT; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            exp_stat(32'(1000 * (i % 10)), 32'(100 - (i % 10)), 1, i == 10);
            tick();
        end
        bus.abort = 1'b1; bus.start = 1'b1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        exp_stat(0, 100, 0, 0);
        tick();
        exp_stat(0, 100, 0, 0);
        tick();
        bus.mode = ONESHOT; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_stat(0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        exp_stat(0, 100, 0, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_stat(32'(1000 * i), 32'(100 - i), 1, 0);
            tick();
        end

        waited = 0;
        while ((stat_q.size() + samp_q.size()) > 0 && waited < 20) begin
            tick();
            waited++;
        end
        check("queues_drained", longint'(stat_q.size() + samp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
